// File: rtl/clk_div_bank.sv
// ============================================================================
// Module   : clk_div_bank
// Brief    : Multi-ratio divided clock with synchronised mode-advance button
//            and manual single-step modes; ratio changes only on boundaries.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_div_bank #(
    parameter int unsigned CNT_W      = 24,
    parameter int unsigned NUM_MODES  = 2,
    parameter int unsigned HALF0      = 6,
    parameter int unsigned HALF1      = 24'h5F5E10,
    parameter int unsigned HALF2      = 1,
    parameter int unsigned HALF3      = 0,
    parameter int unsigned RESET_MODE = 0,
    parameter int unsigned STEP_HIGH  = 4
) (
    input  logic       clkd_clock_i,
    input  logic       clkd_nReset_i,
    input  logic       clkd_switchFreq_i,
    input  logic       clkd_step_i,
    output logic       clkd_genClk_o,
    output logic       clkd_rise_o,
    output logic [1:0] clkd_mode_o,
    output logic       clkd_pend_o
);

    localparam logic [CNT_W-1:0] c_HALF0      = CNT_W'(HALF0);
    localparam logic [CNT_W-1:0] c_HALF1      = CNT_W'(HALF1);
    localparam logic [CNT_W-1:0] c_HALF2      = CNT_W'(HALF2);
    localparam logic [CNT_W-1:0] c_HALF3      = CNT_W'(HALF3);
    localparam logic [CNT_W-1:0] c_STEP_LAST  = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] c_ONE        = CNT_W'(1);
    localparam logic [1:0]       c_LAST_MODE  = 2'(NUM_MODES - 1);
    localparam logic [1:0]       c_RESET_MODE = 2'(RESET_MODE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } stepState_t;

    // Bit 0 carries the switch button, bit 1 the step button.
    logic [1:0] w_btnRaw;
    logic [1:0] r_btnMeta;
    logic [1:0] r_btnSync;
    logic [1:0] r_btnLast;
    logic [1:0] r_btnPulse;
    logic       w_swPulse;
    logic       w_stepPulse;

    logic [1:0]       r_pendMode;
    logic [1:0]       w_pendNext;
    logic [1:0]       r_curMode;
    logic [1:0]       w_modeNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_genClk;
    logic             w_genNext;
    logic             r_rise;
    stepState_t       r_stepState;
    stepState_t       w_stateNext;

    logic [CNT_W-1:0] w_halfCur;
    logic [CNT_W-1:0] w_halfPend;
    logic             w_isStep;
    logic             w_phaseEnd;
    logic             w_stepEnd;

    function automatic logic [CNT_W-1:0] halfOf(input logic [1:0] mode);
        logic [CNT_W-1:0] half;
        case (mode)
            2'd0:    half = c_HALF0;
            2'd1:    half = c_HALF1;
            2'd2:    half = c_HALF2;
            default: half = c_HALF3;
        endcase
        return half;
    endfunction

    assign w_btnRaw    = {clkd_step_i, clkd_switchFreq_i};
    assign w_swPulse   = r_btnPulse[0];
    assign w_stepPulse = r_btnPulse[1];

    always_ff @(posedge clkd_clock_i or negedge clkd_nReset_i) begin
        if (!clkd_nReset_i) begin
            r_btnMeta  <= 2'b00;
            r_btnSync  <= 2'b00;
            r_btnLast  <= 2'b00;
            r_btnPulse <= 2'b00;
        end else begin
            r_btnMeta  <= w_btnRaw;
            r_btnSync  <= r_btnMeta;
            r_btnLast  <= r_btnSync;
            r_btnPulse <= r_btnSync & ~r_btnLast;
        end
    end

    always_comb begin
        w_pendNext = r_pendMode;
        if (w_swPulse) begin
            w_pendNext = (r_pendMode == c_LAST_MODE) ? 2'd0 : r_pendMode + 2'd1;
        end
    end

    assign w_halfCur  = halfOf(r_curMode);
    assign w_halfPend = halfOf(r_pendMode);
    assign w_isStep   = (w_halfCur == '0);
    assign w_phaseEnd = (r_cnt == w_halfCur - c_ONE);
    assign w_stepEnd  = (r_cnt == c_STEP_LAST);

    always_ff @(posedge clkd_clock_i or negedge clkd_nReset_i) begin
        if (!clkd_nReset_i) begin
            r_stepState <= ST_IDLE;
        end else begin
            r_stepState <= w_stateNext;
        end
    end

    always_comb begin
        w_cntNext   = r_cnt;
        w_genNext   = r_genClk;
        w_modeNext  = r_curMode;
        w_stateNext = r_stepState;
        if (!w_isStep) begin
            w_stateNext = ST_IDLE;
            if (w_phaseEnd) begin
                w_cntNext = '0;
                if (!r_genClk) begin
                    // End of low phase: adopt the requested ratio. A step-mode
                    // target keeps the clock low instead of emitting a high phase.
                    w_modeNext = r_pendMode;
                    w_genNext  = (w_halfPend != '0);
                end else begin
                    w_genNext = 1'b0;
                end
            end else begin
                w_cntNext = r_cnt + c_ONE;
            end
        end else begin
            case (r_stepState)
                ST_IDLE: begin
                    w_genNext = 1'b0;
                    if (r_pendMode != r_curMode) begin
                        w_modeNext = r_pendMode;
                        w_cntNext  = '0;
                    end else if (w_stepPulse && !w_swPulse) begin
                        // A step arriving with a switch press is dropped so the
                        // mode change it heralds wins.
                        w_cntNext   = '0;
                        w_genNext   = 1'b1;
                        w_stateNext = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_stepEnd) begin
                        w_cntNext   = '0;
                        w_genNext   = 1'b0;
                        w_stateNext = ST_IDLE;
                    end else begin
                        w_cntNext = r_cnt + c_ONE;
                    end
                end
                default: begin
                    w_genNext   = 1'b0;
                    w_stateNext = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkd_clock_i or negedge clkd_nReset_i) begin
        if (!clkd_nReset_i) begin
            r_cnt      <= '0;
            r_genClk   <= 1'b0;
            r_rise     <= 1'b0;
            r_curMode  <= c_RESET_MODE;
            r_pendMode <= c_RESET_MODE;
        end else begin
            r_cnt      <= w_cntNext;
            r_genClk   <= w_genNext;
            r_rise     <= w_genNext & ~r_genClk;
            r_curMode  <= w_modeNext;
            r_pendMode <= w_pendNext;
        end
    end

    assign clkd_genClk_o = r_genClk;
    assign clkd_rise_o   = r_rise;
    assign clkd_mode_o   = r_curMode;
    assign clkd_pend_o   = (r_pendMode != r_curMode);

endmodule

`default_nettype wire

// File: tb/tb_clk_div_bank.sv
// ============================================================================
// Module   : tb_clk_div_bank
// Brief    : Directed self-checking bench for clk_div_bank (4 modes, HALF1=10).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_div_bank;

    logic       clk;
    logic       nRst;
    logic       sw;
    logic       stp;
    logic       genClk;
    logic       rise;
    logic [1:0] mode;
    logic       pend;

    int nCmp;
    int nBad;

    clk_div_bank #(
        .CNT_W      (24),
        .NUM_MODES  (4),
        .HALF0      (6),
        .HALF1      (10),
        .HALF2      (1),
        .HALF3      (0),
        .RESET_MODE (0),
        .STEP_HIGH  (4)
    ) u_dut (
        .clkd_clock_i      (clk),
        .clkd_nReset_i     (nRst),
        .clkd_switchFreq_i (sw),
        .clkd_step_i       (stp),
        .clkd_genClk_o     (genClk),
        .clkd_rise_o       (rise),
        .clkd_mode_o       (mode),
        .clkd_pend_o       (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nRst = 1'b0;
        sw   = 1'b0;
        stp  = 1'b0;
        adv(3);
        nCmp++; if (genClk !== 1'b0) begin nBad++; $display("FAIL reset_gen got %b exp 0", genClk); end
        nCmp++; if (rise !== 1'b0)   begin nBad++; $display("FAIL reset_rise got %b exp 0", rise); end
        nCmp++; if (mode !== 2'd0)   begin nBad++; $display("FAIL reset_mode got %0d exp 0", mode); end
        nCmp++; if (pend !== 1'b0)   begin nBad++; $display("FAIL reset_pend got %b exp 0", pend); end
        nRst = 1'b1;
    endtask

    // Mode 0, HALF=6: rises on edge 6, period 12.
    task automatic test_freerun();
        logic expGen;
        logic expRise;
        for (int k = 1; k <= 30; k++) begin
            adv(1);
            expGen  = ((k / 6) % 2) == 1;
            expRise = (k % 12) == 6;
            nCmp++; if (genClk !== expGen)  begin nBad++; $display("FAIL freerun_gen k=%0d got %b exp %b", k, genClk, expGen); end
            nCmp++; if (rise !== expRise)   begin nBad++; $display("FAIL freerun_rise k=%0d got %b exp %b", k, rise, expRise); end
        end
        nCmp++; if (mode !== 2'd0) begin nBad++; $display("FAIL freerun_mode got %0d exp 0", mode); end
    endtask

    // Press at edge 31; pend after edge 35; mode 1 applied at rise on edge 42.
    task automatic test_switch();
        adv(1);
        sw = 1'b1;
        for (int e = 32; e <= 62; e++) begin
            adv(1);
            if (e == 33) sw = 1'b0;
            if (e == 34) begin
                nCmp++; if (pend !== 1'b0) begin nBad++; $display("FAIL sw_pend_early e=%0d got %b exp 0", e, pend); end
            end
            if (e == 35) begin
                nCmp++; if (pend !== 1'b1) begin nBad++; $display("FAIL sw_pend_set e=%0d got %b exp 1", e, pend); end
            end
            if (e == 41) begin
                nCmp++; if (mode !== 2'd0)  begin nBad++; $display("FAIL sw_mode_before got %0d exp 0", mode); end
                nCmp++; if (genClk !== 1'b0) begin nBad++; $display("FAIL sw_gen_before got %b exp 0", genClk); end
            end
            if (e == 42) begin
                nCmp++; if (mode !== 2'd1)  begin nBad++; $display("FAIL sw_mode_apply got %0d exp 1", mode); end
                nCmp++; if (genClk !== 1'b1) begin nBad++; $display("FAIL sw_gen_rise got %b exp 1", genClk); end
                nCmp++; if (rise !== 1'b1)   begin nBad++; $display("FAIL sw_rise got %b exp 1", rise); end
                nCmp++; if (pend !== 1'b0)   begin nBad++; $display("FAIL sw_pend_clear got %b exp 0", pend); end
            end
            if (e == 51 || e == 62) begin
                nCmp++; if (genClk !== 1'b1) begin nBad++; $display("FAIL sw_gen_high e=%0d got %b exp 1", e, genClk); end
            end
            if (e == 52 || e == 61) begin
                nCmp++; if (genClk !== 1'b0) begin nBad++; $display("FAIL sw_gen_low e=%0d got %b exp 0", e, genClk); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic expGen;
        adv(3);
        nCmp++; if (genClk !== 1'b1) begin nBad++; $display("FAIL rmid_pre_gen got %b exp 1", genClk); end
        nRst = 1'b0;
        #1;
        nCmp++; if (genClk !== 1'b0) begin nBad++; $display("FAIL rmid_gen got %b exp 0", genClk); end
        nCmp++; if (mode !== 2'd0)   begin nBad++; $display("FAIL rmid_mode got %0d exp 0", mode); end
        nCmp++; if (pend !== 1'b0)   begin nBad++; $display("FAIL rmid_pend got %b exp 0", pend); end
        adv(2);
        nRst = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            adv(1);
            expGen = ((k / 6) % 2) == 1;
            nCmp++; if (genClk !== expGen)       begin nBad++; $display("FAIL rmid_after_gen k=%0d got %b exp %b", k, genClk, expGen); end
            nCmp++; if (rise !== (k == 6))       begin nBad++; $display("FAIL rmid_after_rise k=%0d got %b exp %b", k, rise, (k == 6)); end
        end
    endtask

    // Three presses between boundaries 6 and 18 advance mode 0 -> 3 (step).
    task automatic test_three_presses();
        nRst = 1'b0;
        adv(1);
        nRst = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            adv(1);
            sw = (k == 6 || k == 8 || k == 10);
            if (k == 10) begin
                nCmp++; if (pend !== 1'b1) begin nBad++; $display("FAIL three_pend got %b exp 1", pend); end
            end
            if (k == 17) begin
                nCmp++; if (mode !== 2'd0) begin nBad++; $display("FAIL three_mode_before got %0d exp 0", mode); end
            end
            if (k == 18) begin
                nCmp++; if (mode !== 2'd3) begin nBad++; $display("FAIL three_mode got %0d exp 3", mode); end
                nCmp++; if (pend !== 1'b0) begin nBad++; $display("FAIL three_pend_clear got %b exp 0", pend); end
            end
            if (k >= 12) begin
                nCmp++; if (genClk !== 1'b0 || rise !== 1'b0) begin
                    nBad++; $display("FAIL three_low k=%0d got gen=%b rise=%b exp 0/0", k, genClk, rise);
                end
            end
        end
    endtask

    // Press, ignored press during high, later press: pulses at edges 4..7 and 16..19.
    task automatic test_step();
        logic expGen;
        stp = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            adv(1);
            if (k == 1 || k == 4 || k == 13) stp = 1'b0;
            if (k == 3 || k == 12)           stp = 1'b1;
            expGen = (k >= 4 && k <= 7) || (k >= 16 && k <= 19);
            nCmp++; if (genClk !== expGen)             begin nBad++; $display("FAIL step_gen k=%0d got %b exp %b", k, genClk, expGen); end
            nCmp++; if (rise !== (k == 4 || k == 16))  begin nBad++; $display("FAIL step_rise k=%0d got %b exp %b", k, rise, (k == 4 || k == 16)); end
        end
        nCmp++; if (mode !== 2'd3) begin nBad++; $display("FAIL step_mode got %0d exp 3", mode); end
    endtask

    // Switch and step together in IDLE: mode 3 -> 0, no step, low 6 then rise.
    task automatic test_back_to_back();
        logic expGen;
        sw  = 1'b1;
        stp = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            adv(1);
            if (k == 1) begin
                sw  = 1'b0;
                stp = 1'b0;
            end
            if (k == 4) begin
                nCmp++; if (mode !== 2'd3) begin nBad++; $display("FAIL b2b_mode_pre got %0d exp 3", mode); end
                nCmp++; if (pend !== 1'b1) begin nBad++; $display("FAIL b2b_pend got %b exp 1", pend); end
            end
            if (k == 5) begin
                nCmp++; if (mode !== 2'd0) begin nBad++; $display("FAIL b2b_mode got %0d exp 0", mode); end
                nCmp++; if (pend !== 1'b0) begin nBad++; $display("FAIL b2b_pend_clear got %b exp 0", pend); end
            end
            expGen = (k >= 11 && k <= 16);
            nCmp++; if (genClk !== expGen)   begin nBad++; $display("FAIL b2b_gen k=%0d got %b exp %b", k, genClk, expGen); end
            nCmp++; if (rise !== (k == 11))  begin nBad++; $display("FAIL b2b_rise k=%0d got %b exp %b", k, rise, (k == 11)); end
        end
    endtask

    initial begin
        nCmp = 0;
        nBad = 0;
        nRst = 1'b0;
        sw   = 1'b0;
        stp  = 1'b0;
        test_reset();
        test_freerun();
        test_switch();
        test_reset_mid();
        test_three_presses();
        test_step();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised, multi-ratio clock generator for the development chassis. It derives a divided clock from the board oscillator and offers up to four selectable half-period settings. Any setting can instead be a manual single-step mode. A debounced-by-synchronisation switch button cycles through the settings, and ratio changes take effect only on a period boundary, so no runt pulses reach the core.

## Interface
Parameters:
- CNT_W, 24: counter width; every HALFn must fit in CNT_W bits.
- NUM_MODES, 2: number of active modes, 2..4.
- HALF0, 6: half-period of mode 0, in input-clock cycles. 0 selects manual step mode.
- HALF1, 24'h5F5E10: half-period of mode 1. 0 selects step mode.
- HALF2, 1: half-period of mode 2. 0 selects step mode.
- HALF3, 0: half-period of mode 3. 0 selects step mode.
- RESET_MODE, 0: mode loaded at reset; must be < NUM_MODES.
- STEP_HIGH, 4: high time, in cycles, of one manual step pulse; must be ≥ 1.

Ports:
- clkd_clock_i  in  1  input clock (50 MHz board oscillator).
- clkd_nReset_i  in  1  reset; asynchronous, active-low.
- clkd_switchFreq_i  in  1  asynchronous mode-advance button.
- clkd_step_i  in  1  asynchronous step button; used only in step modes.
- clkd_genClk_o  out  1  generated clock, registered.
- clkd_rise_o  out  1  one-cycle pulse, asserted in the cycle clkd_genClk_o is first high.
- clkd_mode_o  out  2  current mode index.
- clkd_pend_o  out  1  high while the requested mode differs from the current mode.

## Operation
- Synchronisers:
  - Each async button passes through a 2-FF synchroniser, reset to 0.
  - A rising-edge detector (third flop) produces a one-cycle pulse: swPulse or stepPulse.
- Request register pendMode:
  - On swPulse, pendMode ← (pendMode+1) mod NUM_MODES.
  - Multiple presses before a boundary accumulate modulo NUM_MODES.
  - clkd_pend_o = (pendMode != curMode).
- Free-run mode (HALF[curMode] ≥ 1):
  - cnt counts 0..HALF−1 within each phase.
  - When cnt == HALF−1: toggle genClk and set cnt ← 0.
  - Each phase therefore lasts exactly HALF cycles. HALF=1 gives clock/2.
- Boundary (free-run): the cycle in which the low phase ends, i.e. genClk=0 and cnt==HALF−1.
  - curMode ← pendMode, cnt ← 0, genClk rises.
  - The new high phase already uses HALF[new mode].
- Step mode (HALF[curMode] == 0), two states:
  - IDLE: genClk=0. A stepPulse loads cnt ← 0, sets genClk=1 and goes to HIGH.
  - HIGH: lasts STEP_HIGH cycles, then genClk=0 and return to IDLE.
  - stepPulse during HIGH is ignored.
- Step-mode boundary: every IDLE cycle.
  - If pendMode != curMode: curMode ← pendMode, cnt ← 0, genClk stays 0.
  - A free-run target then starts with a full low phase of HALF[new] cycles.
- stepPulse in free-run modes is ignored.

## Timing
- Reset values: clkd_genClk_o=0, clkd_rise_o=0, clkd_mode_o=RESET_MODE, clkd_pend_o=0; cnt=0, pendMode=RESET_MODE, all synchroniser/edge flops 0, step state IDLE.
- First edge after reset release, free-run mode: genClk rises on the HALF-th clock edge after reset deasserts.
- Button latency: from a switch/step input rising to its pulse is 3 clock edges; clkd_pend_o follows on the next edge.
- Simultaneous events:
  - swPulse in a boundary cycle: the boundary loads the old pendMode, and the press applies at the next boundary.
  - In step IDLE, stepPulse together with a pending mode change: the mode change wins and the step is discarded.
- Reset mid-operation: everything returns to reset values asynchronously. genClk drops immediately, including mid-high-phase; no completion of the period.
- Width rules: cnt is CNT_W bits and compares with equality only.
- Guarantee: no high or low phase is shorter than min(HALF of either mode involved, STEP_HIGH).

## Test plan
- Reset, defaults, mode 0 (HALF=6): genClk rises 6 cycles after reset release, then period 12, duty 50%; clkd_rise_o pulses once per period.
- One switch press while in mode 0:
  - clkd_pend_o goes high 4 edges after the press.
  - Mode 1 is applied exactly at the next low→high edge; clkd_mode_o=1.
  - High phase lasts 0x5F5E10 cycles (use override HALF1=10 for sim).
- Three presses within one period, NUM_MODES=4 (HALF2=1, HALF3=0): at the next boundary clkd_mode_o=3 and genClk then stays low, with no runt pulse.
- Step mode (mode 3):
  - A step press produces exactly STEP_HIGH=4 high cycles.
  - A second press during high is ignored.
  - A press after return to low gives a second pulse.
- Press switch and step together while in step IDLE: mode advances to 0, no step pulse; genClk low for 6 cycles, then free-runs.
- Assert clkd_nReset_i mid high phase: genClk=0 and clkd_mode_o=RESET_MODE immediately; after release, behaviour matches the first scenario.
